// File: rtl/axil_slave_ram.sv
// AXI-Lite slave RAM endpoint: decodes its own address window, byte-strobed word RAM, delayed OKAY/DECERR responses.
// Define AXIL_SLAVE_RAM_RAND_DELAY_EN for LFSR-randomised response delay; otherwise delay is AXI_TRAN_MIN_DELAY.
//
// state   | meaning
// W_IDLE  | collecting AW and W in any order
// W_DELAY | response delay countdown, RAM written on exit
// W_RESP  | bvalid held until bready
// R_IDLE  | waiting for AR, RAM word sampled on capture
// R_DELAY | response delay countdown
// R_RESP  | rvalid held until rready
module axil_slave_ram #(
    parameter int                        AXI_DATA_WIDTH     = 32,
    parameter int                        AXI_ADDR_WIDTH     = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET    = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE     = 32'h0000_FFFF,
    parameter int                        MEM_DEPTH          = 256,
    parameter int                        AXI_TRAN_MIN_DELAY = 2,
    parameter int                        AXI_TRAN_MAX_DELAY = 17
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready
);

    localparam int STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int CNT_W   = $clog2(AXI_TRAN_MAX_DELAY + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;

    // Unsigned wrap of the subtraction makes addresses below the base fail the range compare.
    function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = addr - AXI_ADDR_OFFSET;
        return (off <= AXI_ADDR_RANGE);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - AXI_ADDR_OFFSET) >> BYTE_SH);
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t                  w_state;
    logic [CNT_W-1:0]          w_cnt;
    logic                      aw_got;
    logic                      w_got;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;

    r_state_t                  r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
    logic [AXI_DATA_WIDTH-1:0] rd_word;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic aw_done;
    logic w_done;
    logic w_accept;
    logic w_commit;
    logic mem_we;
    logic [CNT_W-1:0] w_delay;
    logic [CNT_W-1:0] r_delay;

    assign aw_hs    = s_axil_awvalid && s_axil_awready;
    assign w_hs     = s_axil_wvalid && s_axil_wready;
    assign ar_hs    = s_axil_arvalid && s_axil_arready;
    assign aw_done  = aw_got || aw_hs;
    assign w_done   = w_got || w_hs;
    assign w_accept = (w_state == W_IDLE) && aw_done && w_done;
    assign w_commit = (w_state == W_DELAY) && (w_cnt == CNT_LAST);
    assign mem_we   = w_commit && in_window(aw_addr_q) && !areset;

`ifdef AXIL_SLAVE_RAM_RAND_DELAY_EN
    localparam int unsigned SPAN = AXI_TRAN_MAX_DELAY - AXI_TRAN_MIN_DELAY + 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [CNT_W-1:0] pick_delay(input logic [15:0] l);
        int unsigned v;
        v = 32'(AXI_TRAN_MIN_DELAY) + (32'(l) % SPAN);
        return CNT_W'(v);
    endfunction

    logic [15:0] w_lfsr;
    logic [15:0] r_lfsr;

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_lfsr <= LFSR_SEED;
            r_lfsr <= LFSR_SEED;
        end else begin
            if (w_accept) w_lfsr <= lfsr_next(w_lfsr);
            if (ar_hs)    r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_delay = pick_delay(w_lfsr);
    assign r_delay = pick_delay(r_lfsr);
`else
    assign w_delay = CNT_W'(AXI_TRAN_MIN_DELAY);
    assign r_delay = CNT_W'(AXI_TRAN_MIN_DELAY);
`endif

    // The read word is sampled at AR capture, so a same-edge write commit is not visible to it.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) mem[word_idx(aw_addr_q)][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
        end
        if (ar_hs) rd_word <= mem[word_idx(s_axil_araddr)];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state        <= W_IDLE;
            w_cnt          <= '0;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) aw_addr_q <= s_axil_awaddr;
                    if (w_hs) begin
                        w_data_q <= s_axil_wdata;
                        w_strb_q <= s_axil_wstrb;
                    end
                    if (w_accept) begin
                        w_state        <= W_DELAY;
                        w_cnt          <= w_delay;
                        aw_got         <= 1'b0;
                        w_got          <= 1'b0;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b0;
                    end else begin
                        aw_got         <= aw_done;
                        w_got          <= w_done;
                        s_axil_awready <= !aw_done;
                        s_axil_wready  <= !w_done;
                    end
                end
                W_DELAY: begin
                    if (w_cnt == CNT_LAST) begin
                        w_state       <= W_RESP;
                        w_cnt         <= '0;
                        s_axil_bvalid <= 1'b1;
                        s_axil_bresp  <= in_window(aw_addr_q) ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        w_cnt <= w_cnt - CNT_LAST;
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        w_state        <= W_IDLE;
                        s_axil_bvalid  <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= R_IDLE;
            r_cnt          <= '0;
            ar_addr_q      <= '0;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state        <= R_DELAY;
                        r_cnt          <= r_delay;
                        ar_addr_q      <= s_axil_araddr;
                        s_axil_arready <= 1'b0;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                R_DELAY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state       <= R_RESP;
                        r_cnt         <= '0;
                        s_axil_rvalid <= 1'b1;
                        if (in_window(ar_addr_q)) begin
                            s_axil_rdata <= rd_word;
                            s_axil_rresp <= RESP_OKAY;
                        end else begin
                            s_axil_rdata <= '0;
                            s_axil_rresp <= RESP_DECERR;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_LAST;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready) begin
                        r_state        <= R_IDLE;
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_slave_ram.sv
// Bench for axil_slave_ram: vector table through a response scoreboard, plus backpressure, reset and ordering sequences.
module tb_axil_slave_ram;

    localparam int          D      = 2;
    localparam logic [31:0] OFFSET = 32'h1000_0000;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [31:0] s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;

    axil_slave_ram #(
        .AXI_ADDR_OFFSET(OFFSET)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[16];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        e.resp = resp;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // lead > 0: W offered lead cycles before AW; lead < 0: AW offered first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int hold);
        bit   aw_done = 0;
        bit   w_done = 0;
        bit   aw_hs, w_hs;
        int   k = 0;
        int   n = 0;
        int   aw_start = (lead > 0) ? lead : 0;
        int   w_start = (lead < 0) ? -lead : 0;
        exp_t e;
        e = exp_q.pop_front();
        s_axil_awaddr = addr;
        s_axil_wdata  = data;
        s_axil_wstrb  = strb;
        while (!(aw_done && w_done) && k < 60) begin
            s_axil_awvalid = !aw_done && (k >= aw_start);
            s_axil_wvalid  = !w_done && (k >= w_start);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            step();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            k++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("aw_w_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        while (!s_axil_bvalid && n < 50) begin
            step();
            n++;
        end
        check("b_latency", 32'(n), 32'(D));
        if (!s_axil_bvalid) return;
        for (int h = 0; h < hold; h++) begin
            check("bvalid_hold", 32'(s_axil_bvalid), 32'd1);
            check("bresp_hold", 32'(s_axil_bresp), 32'(e.resp));
            check("awready_wready_low", 32'({s_axil_awready, s_axil_wready}), 32'd0);
            step();
        end
        check("bresp", 32'(s_axil_bresp), 32'(e.resp));
        s_axil_bready = 1'b1;
        step();
        s_axil_bready = 1'b0;
        check("w_rearm", 32'({s_axil_awready, s_axil_wready, s_axil_bvalid}), 32'b110);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        bit   hs = 0;
        int   k = 0;
        int   n = 0;
        exp_t e;
        e = exp_q.pop_front();
        s_axil_araddr = addr;
        while (!hs && k < 60) begin
            s_axil_arvalid = 1'b1;
            hs = s_axil_arready;
            step();
            k++;
        end
        s_axil_arvalid = 1'b0;
        if (!hs) begin
            check("ar_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        while (!s_axil_rvalid && n < 50) begin
            step();
            n++;
        end
        check("r_latency", 32'(n), 32'(D));
        if (!s_axil_rvalid) return;
        for (int h = 0; h < hold; h++) begin
            check("rvalid_hold", 32'(s_axil_rvalid), 32'd1);
            check("rdata_hold", s_axil_rdata, e.data);
            check("rresp_hold", 32'(s_axil_rresp), 32'(e.resp));
            check("arready_low", 32'(s_axil_arready), 32'd0);
            step();
        end
        check("rresp", 32'(s_axil_rresp), 32'(e.resp));
        check("rdata", s_axil_rdata, e.data);
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;
        check("r_rearm", 32'({s_axil_arready, s_axil_rvalid}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_b;
        int n;

        vecs[0]  = '{0, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF,  0, 2'b00, 32'h0};
        vecs[1]  = '{1, 32'h1000_0010, 32'h0,         4'h0,  0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{0, 32'h1000_0010, 32'h1234_5678, 4'h3,  4, 2'b00, 32'h0};
        vecs[3]  = '{1, 32'h1000_0010, 32'h0,         4'h0,  0, 2'b00, 32'hDEAD_5678};
        vecs[4]  = '{0, 32'h1000_0000, 32'hCAFE_F00D, 4'hF, -3, 2'b00, 32'h0};
        vecs[5]  = '{0, 32'h1001_0000, 32'hAAAA_5555, 4'hF,  0, 2'b11, 32'h0};
        vecs[6]  = '{1, 32'h1001_0000, 32'h0,         4'h0,  0, 2'b11, 32'h0};
        vecs[7]  = '{1, 32'h1000_0000, 32'h0,         4'h0,  0, 2'b00, 32'hCAFE_F00D};
        vecs[8]  = '{1, 32'h0FFF_FFFC, 32'h0,         4'h0,  0, 2'b11, 32'h0};
        vecs[9]  = '{1, 32'h1000_0013, 32'h0,         4'h0,  0, 2'b00, 32'hDEAD_5678};
        vecs[10] = '{0, 32'h1000_FFFC, 32'h0BAD_CAFE, 4'hF,  1, 2'b00, 32'h0};
        vecs[11] = '{0, 32'h1000_FFFC, 32'h1122_3344, 4'hC, -1, 2'b00, 32'h0};
        vecs[12] = '{1, 32'h1000_FFFC, 32'h0,         4'h0,  0, 2'b00, 32'h1122_CAFE};
        vecs[13] = '{1, 32'h1000_03FC, 32'h0,         4'h0,  0, 2'b00, 32'h1122_CAFE};
        vecs[14] = '{0, 32'h1000_0020, 32'h0000_1111, 4'hF,  0, 2'b00, 32'h0};
        vecs[15] = '{1, 32'h1000_0020, 32'h0,         4'h0,  0, 2'b00, 32'h0000_1111};

        areset = 1'b1;
        step();
        step();
        check("rst_readies", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
        check("rst_valids", 32'({s_axil_bvalid, s_axil_rvalid}), 32'd0);
        check("rst_resps", 32'({s_axil_bresp, s_axil_rresp}), 32'd0);
        check("rst_rdata", s_axil_rdata, 32'd0);
        areset = 1'b0;
        step();
        check("readies_after_rst", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'b111);

        foreach (vecs[i]) begin
            push_exp(vecs[i].exp_resp, vecs[i].exp_data);
            if (vecs[i].rd) do_read(vecs[i].addr, 0);
            else            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, 0);
        end

        // Backpressure: responses held 5 cycles with ready low.
        push_exp(2'b00, 32'h0);
        do_write(32'h1000_0040, 32'h5A5A_A5A5, 4'hF, 0, 5);
        push_exp(2'b00, 32'h5A5A_A5A5);
        do_read(32'h1000_0040, 5);

        // Reset lands on the commit edge of a pending write.
        s_axil_awaddr  = 32'h1000_0010;
        s_axil_wdata   = 32'hFFFF_FFFF;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        check("pre_rst_readies", 32'({s_axil_awready, s_axil_wready}), 32'b11);
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("mid_rst_readies", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
        seen_b = 1'b0;
        step();
        check("readies_after_pulse", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'b111);
        for (int c = 0; c < 8; c++) begin
            seen_b |= s_axil_bvalid;
            step();
        end
        check("no_b_after_rst", 32'(seen_b), 32'd0);
        push_exp(2'b00, 32'hDEAD_5678);
        do_read(32'h1000_0010, 0);

        // Write commit and read capture on the same edge, same word.
        s_axil_awaddr  = 32'h1000_0020;
        s_axil_wdata   = 32'h2222_3333;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        step();
        s_axil_araddr  = 32'h1000_0020;
        s_axil_arvalid = 1'b1;
        check("race_arready", 32'(s_axil_arready), 32'd1);
        step();
        s_axil_arvalid = 1'b0;
        check("race_bvalid", 32'(s_axil_bvalid), 32'd1);
        check("race_bresp", 32'(s_axil_bresp), 32'd0);
        s_axil_bready = 1'b1;
        step();
        s_axil_bready = 1'b0;
        n = 1;
        while (!s_axil_rvalid && n < 50) begin
            step();
            n++;
        end
        check("race_r_latency", 32'(n), 32'(D));
        check("race_rdata_old", s_axil_rdata, 32'h0000_1111);
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;
        push_exp(2'b00, 32'h2222_3333);
        do_read(32'h1000_0020, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axil_slave_ram.md
# axil_slave_ram

AXI-Lite slave memory endpoint that attaches to one slave port of the priority AXI-Lite interconnect and serves as its downstream consumer. It decodes its own address window (offset plus range), stores data in an internal word-addressed RAM with byte strobes, and returns SLVERR-free OKAY or DECERR responses after a programmable response delay. Sixteen instances, one per interconnect slave port, form the system-level memory map target.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64
- AXI_ADDR_WIDTH, 32, address bus width
- AXI_ADDR_OFFSET, 32'h0000_0000, window base address
- AXI_ADDR_RANGE, 32'h0000_FFFF, window size minus one; valid iff 0 <= addr - OFFSET <= RANGE
- MEM_DEPTH, 256, RAM depth in words; power of two
- AXI_TRAN_MIN_DELAY, 2, minimum response delay in cycles; >= 1
- AXI_TRAN_MAX_DELAY, 17, maximum response delay in cycles; >= MIN

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  reset; synchronous, active-high
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake
- s_axil_wdata  in  AXI_DATA_WIDTH  write data
- s_axil_wstrb  in  AXI_DATA_WIDTH/8  byte enables
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake
- s_axil_bresp  out  2  write response
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake
- s_axil_araddr  in  AXI_ADDR_WIDTH  read address
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake
- s_axil_rdata  out  AXI_DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake

## Operation
- Write and read channels run independent FSMs; one outstanding transaction each.
- Write FSM: W_IDLE -> W_DELAY -> W_RESP -> W_IDLE.
  - W_IDLE: awready and wready high until their own handshake; AW and W captured independently in either order or same cycle; once one is captured its ready drops.
  - Both captured -> W_DELAY with counter = D. Counter decrements each cycle; at 1 -> W_RESP.
  - Entering W_RESP: if address in window and OKAY, RAM[(addr-OFFSET)>>log2(bytes) mod MEM_DEPTH] updated per wstrb; bresp = 2'b00. Out of window: no write, bresp = 2'b11 (DECERR).
  - W_RESP: bvalid held with stable bresp until bready; handshake -> W_IDLE.
- Read FSM: R_IDLE -> R_DELAY -> R_RESP -> R_IDLE.
  - R_IDLE: arready high; handshake captures araddr -> R_DELAY counter = D.
  - Entering R_RESP: rdata = RAM word (in window, rresp 2'b00) or all-zero (out of window, rresp 2'b11).
  - R_RESP: rvalid, rdata, rresp stable until rready.
- Address low bits below word granularity ignored; window check uses full address.
- Same-cycle write commit and read capture to same word: read returns pre-write value.
- RAM contents not cleared by reset.

## Timing
- Reset values: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0. Readies rise in the first cycle after areset deasserts.
- Last of AW/W handshakes in cycle T -> bvalid high in cycle T+D+1. AR handshake in cycle T -> rvalid high in cycle T+D+1.
- Next address accepted the cycle after B/R handshake (readies re-assert then); no back-to-back in consecutive cycles.
- areset asserted in any state: both FSMs to IDLE next edge, pending transaction dropped, counters zeroed; no partial RAM write.

## Configuration
- AXIL_SLAVE_RAM_RAND_DELAY_EN defined: D = MIN + (lfsr mod (MAX-MIN+1)); 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, steps once per accepted transaction (write and read each own LFSR, same seed).
- Not defined: D = AXI_TRAN_MIN_DELAY fixed; no LFSR logic.

## Test plan
All with macro undefined, defaults (D=2), OFFSET 32'h1000_0000.
- AW 32'h1000_0010 and W 32'hDEAD_BEEF strb 4'hF same cycle T -> bvalid at T+3, bresp 00; AR 32'h1000_0010 -> rdata 32'hDEAD_BEEF, rresp 00.
- W before AW by 4 cycles, strb 4'b0011 data 32'h1234_5678 over 32'hDEAD_BEEF -> read returns 32'hDEAD_5678.
- AW 32'h1001_0000 (outside range) -> bresp 11, RAM unchanged; AR 32'h0FFF_FFFC -> rdata 0, rresp 11.
- bready/rready held low 5 cycles -> bvalid/rvalid and response fields stable all 5 cycles; readies stay low until handshake.
- areset pulsed during W_DELAY -> bvalid never asserts, target word keeps old value, readies high the cycle after release.
- Write commit and read capture same cycle, same word -> read returns old value; subsequent read returns new.
